// File: rtl/melody_player_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// melody_player_pkg - FSM encoding, END marker and piano-key half-period math
// Rev 1.0
// ---------------------------------------------------------------------------
package melody_player_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PLAY = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // ROM entries are {note, dur} with dur in the low bits; dur==END_DUR ends a melody
   localparam int unsigned END_DUR    = 0;
   localparam int unsigned PIANO_KEYS = 88;
   localparam int unsigned A0_X2_HZ   = 55;

   // 2^(semi/12) in Q16
   function automatic longint unsigned semi_ratio(input int unsigned semi);
      case (semi)
         1:       semi_ratio = 64'd69433;
         2:       semi_ratio = 64'd73562;
         3:       semi_ratio = 64'd77936;
         4:       semi_ratio = 64'd82570;
         5:       semi_ratio = 64'd87480;
         6:       semi_ratio = 64'd92682;
         7:       semi_ratio = 64'd98193;
         8:       semi_ratio = 64'd104032;
         9:       semi_ratio = 64'd110218;
         10:      semi_ratio = 64'd116772;
         11:      semi_ratio = 64'd123715;
         default: semi_ratio = 64'd65536;
      endcase
   endfunction

   // Rounded CLK_HZ/(2*f(n)); key 1 is A0, each octave up halves the period
   function automatic int unsigned half_period(input longint unsigned clk_hz,
                                               input int unsigned n);
      longint unsigned den;
      longint unsigned hp;
      if (n == 0 || n > PIANO_KEYS) return 32'd0;
      den = (64'(A0_X2_HZ) * semi_ratio((n - 1) % 12)) << ((n - 1) / 12);
      hp  = (clk_hz * 64'd65536 + den / 2) / den;
      return (hp == 0) ? 32'd1 : 32'(hp);
   endfunction

endpackage
`default_nettype wire

// File: rtl/melody_player_tone_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// melody_player_tone_gen - toggling divider: sound flips every half_period cycles
// Rev 1.0
// ---------------------------------------------------------------------------
module melody_player_tone_gen #(
   parameter int unsigned HP_W = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic [HP_W-1:0] half_period,
   output logic            sound
);

   logic [HP_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         sound <= 1'b0;
      end else if (clear || half_period == '0) begin
         cnt   <= '0;
         sound <= 1'b0;
      end else if (cnt == half_period - HP_W'(1)) begin
         cnt   <= '0;
         sound <= ~sound;
      end else begin
         cnt <= cnt + HP_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/melody_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// melody_player - plays {note, duration} melodies from an internal ROM on a buzzer
// Rev 1.0
// ---------------------------------------------------------------------------
module melody_player
   import melody_player_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned TICK_DIV = 3_125_000,
   parameter int unsigned GAP_CYC  = 250_000,
   parameter int unsigned N_SONGS  = 4,
   parameter int unsigned SONG_LEN = 32,
   parameter int unsigned NOTE_W   = 7,
   parameter int unsigned DUR_W    = 4,
   localparam int unsigned SEL_W   = (N_SONGS > 1) ? $clog2(N_SONGS) : 1
) (
   input  logic              CLOCK_50,
   input  logic              RESETN,
   input  logic              enable,
   input  logic              start,
   input  logic [SEL_W-1:0]  song_sel,
   input  logic              loop,
   output logic              sound,
   output logic              busy,
   output logic              done,
   output logic [NOTE_W-1:0] note_idx
);

   localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int unsigned POS_W   = $clog2(SONG_LEN + 1);
   localparam int unsigned HP_MAX  = half_period(64'(CLK_HZ), 1);
   localparam int unsigned HP_W    = $clog2(HP_MAX + 1);
   localparam int unsigned N_NOTES = 2 ** NOTE_W;
   localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

   function automatic logic [ENTRY_W-1:0] entry(input int unsigned n, input int unsigned d);
      return {NOTE_W'(n), DUR_W'(d)};
   endfunction

   // Melody s, entry p; unlisted addresses read as the END marker
   function automatic logic [ENTRY_W-1:0] rom(input logic [SEL_W-1:0] s,
                                              input logic [POS_W-1:0] p);
      rom = entry(0, END_DUR);
      case (int'(s))
         0: case (int'(p)) 0: rom = entry(49, 2); default: ; endcase
         1: case (int'(p)) 0: rom = entry(0, 1);  default: ; endcase
         2: case (int'(p)) 0: rom = entry(49, 1); default: ; endcase
         3: case (int'(p))
               0:  rom = entry(40, 1); 1:  rom = entry(41, 1); 2:  rom = entry(42, 1); 3:  rom = entry(43, 1);
               4:  rom = entry(44, 1); 5:  rom = entry(45, 1); 6:  rom = entry(46, 1); 7:  rom = entry(47, 1);
               8:  rom = entry(48, 1); 9:  rom = entry(49, 1); 10: rom = entry(50, 1); 11: rom = entry(51, 1);
               12: rom = entry(52, 1); 13: rom = entry(53, 1); 14: rom = entry(54, 1); 15: rom = entry(55, 1);
               16: rom = entry(56, 1); 17: rom = entry(57, 1); 18: rom = entry(58, 1); 19: rom = entry(59, 1);
               20: rom = entry(60, 1); 21: rom = entry(61, 1); 22: rom = entry(62, 1); 23: rom = entry(63, 1);
               24: rom = entry(64, 1); 25: rom = entry(65, 1); 26: rom = entry(66, 1); 27: rom = entry(67, 1);
               28: rom = entry(68, 1); 29: rom = entry(69, 1); 30: rom = entry(70, 1); 31: rom = entry(71, 1);
               default: ;
            endcase
         default: ;
      endcase
   endfunction

   logic [HP_W-1:0] hp_tab [N_NOTES];

   for (genvar n = 0; n < N_NOTES; n++) begin : g_hp
      assign hp_tab[n] = HP_W'(half_period(64'(CLK_HZ), n));
   end

   state_t              state;
   logic [SEL_W-1:0]    song;
   logic [POS_W-1:0]    pos;
   logic [NOTE_W-1:0]   note;
   logic [DUR_W-1:0]    dur;
   logic [TICK_W-1:0]   tick;
   logic [DUR_W-1:0]    dcnt;
   logic [GAP_W-1:0]    gcnt;

   logic [ENTRY_W-1:0]  rom_entry;
   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;
   logic                last_tick;
   logic                play_last;
   logic                song_end;
   logic                tone_clear;

   assign rom_entry  = rom(song, pos);
   assign rom_note   = rom_entry[ENTRY_W-1:DUR_W];
   assign rom_dur    = rom_entry[DUR_W-1:0];
   assign last_tick  = (tick == TICK_W'(TICK_DIV - 1));
   assign play_last  = (state == S_PLAY) && last_tick && (dcnt == dur - DUR_W'(1));
   assign song_end   = (pos == POS_W'(SONG_LEN)) || (rom_dur == DUR_W'(END_DUR));
   // Clearing on the final PLAY cycle makes sound low exactly when PLAY ends
   assign tone_clear = (state != S_PLAY) || play_last || !enable;

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state    <= S_IDLE;
         song     <= '0;
         pos      <= '0;
         note     <= '0;
         dur      <= '0;
         tick     <= '0;
         dcnt     <= '0;
         gcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         note_idx <= '0;
      end else if (!enable) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         note_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_LOAD;
                  song  <= song_sel;
                  pos   <= '0;
                  busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               if (song_end) begin
                  if (loop) begin
                     pos <= '0;
                  end else begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  note     <= rom_note;
                  dur      <= rom_dur;
                  tick     <= '0;
                  dcnt     <= '0;
                  note_idx <= rom_note;
                  state    <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (last_tick) begin
                  tick <= '0;
                  if (play_last) begin
                     note_idx <= '0;
                     gcnt     <= '0;
                     if (GAP_CYC > 0) begin
                        state <= S_GAP;
                     end else begin
                        pos   <= pos + POS_W'(1);
                        state <= S_LOAD;
                     end
                  end else begin
                     dcnt <= dcnt + DUR_W'(1);
                  end
               end else begin
                  tick <= tick + TICK_W'(1);
               end
            end
            S_GAP: begin
               if (gcnt == GAP_W'(GAP_CYC - 1)) begin
                  pos   <= pos + POS_W'(1);
                  state <= S_LOAD;
               end else begin
                  gcnt <= gcnt + GAP_W'(1);
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   melody_player_tone_gen #(
      .HP_W(HP_W)
   ) u_tone (
      .clk        (CLOCK_50),
      .rst_n      (RESETN),
      .clear      (tone_clear),
      .half_period(hp_tab[note]),
      .sound      (sound)
   );

endmodule
`default_nettype wire
